clt_gauss_sampler: RTL and testbench

- Downstream consumer of the free-running 4×32-bit uniform LFSR bus in the multihat Gaussian RNG.
- Takes the top U_BITS of each 32-bit word and accumulates them over N_ACC beats (K = 4·N_ACC uniforms per sample).
- Emits one zero-centred signed central-limit-theorem (CLT) sample per N_ACC beats through a valid/ready output buffer.
- Sits between my_lfsr-style sources and the hat-selection / scaling stages.

---
 rtl/gauss_pkg.sv | 27 ++
 rtl/sample_fifo.sv | 84 ++++++++
 rtl/clt_gauss_sampler.sv | 135 +++++++++++++
 tb/tb_clt_gauss_sampler.sv | 272 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/gauss_pkg.sv
// ============================================================================
// gauss_pkg : shared widths, centring offset and sample type for the
//             CLT Gaussian sampler.
// Rev 1.0
// ============================================================================
`default_nettype none

package gauss_pkg;

    function automatic int out_width(input int u_bits, input int n_acc);
        return u_bits + $clog2(4 * n_acc) + 1;
    endfunction

    // Mean of the doubled sum: K uniforms, each centred at (2^U_BITS-1)/2.
    function automatic logic [63:0] centre_offset(input int k, input int u_bits);
        logic [63:0] umax;
        umax = (64'd1 << u_bits) - 64'd1;
        return umax * 64'(k);
    endfunction

    localparam int DEF_W = out_width(8, 4);

    typedef logic signed [DEF_W-1:0] sample_t;

endpackage

`default_nettype wire

// File: rtl/sample_fifo.sv
// ============================================================================
// sample_fifo : synchronous FIFO with async active-low reset, exposing
//               count / full / empty.
// Rev 1.0
// ============================================================================
`default_nettype none

module sample_fifo #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 2,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic [PTR_W-1:0] wr_q, wr_d;
    logic [PTR_W-1:0] rd_q, rd_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push;
    logic             do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? '0 : p + 1'b1;
    endfunction

    always_comb begin
        full    = (count_q == DEPTH_CNT);
        empty   = (count_q == '0);
        do_push = push && !full;
        do_pop  = pop && !empty;

        mem_d = mem_q;
        if (do_push) begin
            mem_d[wr_q] = push_data;
        end
        wr_d = do_push ? next_ptr(wr_q) : wr_q;
        rd_d = do_pop  ? next_ptr(rd_q) : rd_q;

        count_d = count_q;
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
            wr_q    <= '0;
            rd_q    <= '0;
            count_q <= '0;
        end else begin
            mem_q   <= mem_d;
            wr_q    <= wr_d;
            rd_q    <= rd_d;
            count_q <= count_d;
        end
    end

    assign pop_data = mem_q[rd_q];
    assign count    = count_q;

    a_no_overflow: assert property (@(posedge clk) disable iff (!rst_n) !(push && full));

endmodule

`default_nettype wire

// File: rtl/clt_gauss_sampler.sv
// ============================================================================
// clt_gauss_sampler : sums the top U_BITS of 4 uniform words over N_ACC beats
//                     and emits one zero-centred signed CLT sample per group.
// Rev 1.0
// ============================================================================
`default_nettype none

module clt_gauss_sampler
    import gauss_pkg::*;
#(
    parameter int U_BITS     = 8,
    parameter int N_ACC      = 4,
    parameter int FIFO_DEPTH = 2,
    localparam int W_OUT     = out_width(U_BITS, N_ACC),
    localparam int PH_W      = (N_ACC > 1) ? $clog2(N_ACC) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_u0,
    input  logic [31:0]      in_u1,
    input  logic [31:0]      in_u2,
    input  logic [31:0]      in_u3,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [W_OUT-1:0] out_sample,
    output logic [PH_W-1:0]  acc_phase
);

    localparam int K      = 4 * N_ACC;
    localparam int ACC_W  = W_OUT - 1;
    localparam int PSUM_W = U_BITS + 2;
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);

    localparam logic [W_OUT-1:0] OFFSET    = W_OUT'(centre_offset(K, U_BITS));
    localparam logic [PH_W-1:0]  LAST_PH   = PH_W'(N_ACC - 1);
    localparam logic [CNT_W:0]   DEPTH_CNT = (CNT_W + 1)'(FIFO_DEPTH);

    logic              s1_valid_q, s1_valid_d;
    logic              s1_last_q,  s1_last_d;
    logic [PSUM_W-1:0] psum_q,     psum_d;
    logic [PH_W-1:0]   phase_q,    phase_d;
    logic [ACC_W-1:0]  acc_q,      acc_d;

    logic              accept;
    logic              pending;
    logic [CNT_W:0]    used;
    logic [ACC_W-1:0]  total;
    logic              push;
    logic [W_OUT-1:0]  push_data;
    logic              pop;
    logic [CNT_W-1:0]  fifo_count;
    logic              fifo_full;
    logic              fifo_empty;
    logic              unused_lsbs;

    // Credit counts a sample still in stage 2 so the FIFO can never overflow.
    always_comb begin
        pending  = s1_valid_q && s1_last_q;
        used     = {1'b0, fifo_count} + (CNT_W + 1)'(pending);
        in_ready = reset && !fifo_full && (used < DEPTH_CNT);
        accept   = in_valid && in_ready;
    end

    always_comb begin
        psum_d     = psum_q;
        s1_last_d  = s1_last_q;
        phase_d    = phase_q;
        s1_valid_d = accept && !flush;
        if (accept) begin
            psum_d    = PSUM_W'(in_u0[31 -: U_BITS]) + PSUM_W'(in_u1[31 -: U_BITS])
                      + PSUM_W'(in_u2[31 -: U_BITS]) + PSUM_W'(in_u3[31 -: U_BITS]);
            s1_last_d = (phase_q == LAST_PH);
            phase_d   = (phase_q == LAST_PH) ? '0 : phase_q + 1'b1;
        end
        if (flush) begin
            phase_d = '0;
        end
    end

    always_comb begin
        total     = acc_q + ACC_W'(psum_q);
        push      = s1_valid_q && s1_last_q && !flush;
        push_data = {total, 1'b0} - OFFSET;
        acc_d     = acc_q;
        if (s1_valid_q) begin
            acc_d = s1_last_q ? '0 : total;
        end
        if (flush) begin
            acc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            s1_valid_q <= 1'b0;
            s1_last_q  <= 1'b0;
            psum_q     <= '0;
            phase_q    <= '0;
            acc_q      <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_last_q  <= s1_last_d;
            psum_q     <= psum_d;
            phase_q    <= phase_d;
            acc_q      <= acc_d;
        end
    end

    assign pop = out_ready && !fifo_empty;

    sample_fifo #(
        .WIDTH (W_OUT),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (reset),
        .push      (push),
        .push_data (push_data),
        .pop       (pop),
        .pop_data  (out_sample),
        .count     (fifo_count),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    assign out_valid   = !fifo_empty;
    assign acc_phase   = phase_q;
    assign unused_lsbs = ^{in_u0, in_u1, in_u2, in_u3};

endmodule

`default_nettype wire

// File: tb/tb_clt_gauss_sampler.sv
// ============================================================================
// tb_clt_gauss_sampler : directed, table-driven bench for clt_gauss_sampler.
// Rev 1.0
// ============================================================================
`default_nettype none

module tb_clt_gauss_sampler;
    import gauss_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_u0, in_u1, in_u2, in_u3;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    sample_t     out_sample;
    logic [1:0]  acc_phase;

    clt_gauss_sampler dut (
        .clk        (clk),
        .reset      (reset),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_u0      (in_u0),
        .in_u1      (in_u1),
        .in_u2      (in_u2),
        .in_u3      (in_u3),
        .flush      (flush),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_sample (out_sample),
        .acc_phase  (acc_phase)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][127:0] beats;
        int                exp;
    } vec_t;

    vec_t   vecs [7];
    int     n_cmp = 0;
    int     n_err = 0;
    longint exp_q [$];
    bit     mon_en = 1'b0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Top byte carries the uniform; low 24 bits are noise that must be ignored.
    function automatic logic [127:0] mk(input logic [7:0] a, input logic [7:0] b,
                                        input logic [7:0] c, input logic [7:0] d);
        return {d, 24'h3C5A96, c, 24'hA5C3F0, b, 24'h5A5A5A, a, 24'h0F1E2D};
    endfunction

    function automatic vec_t mkv(input logic [127:0] b0, input logic [127:0] b1,
                                 input logic [127:0] b2, input logic [127:0] b3,
                                 input int e);
        vec_t v;
        v.beats[0] = b0;
        v.beats[1] = b1;
        v.beats[2] = b2;
        v.beats[3] = b3;
        v.exp      = e;
        return v;
    endfunction

    task automatic drive(input logic [127:0] w);
        {in_u3, in_u2, in_u1, in_u0} = w;
    endtask

    // Called at a negedge; returns at the negedge right after the accepting edge.
    task automatic send_beat(input logic [127:0] w);
        int t;
        drive(w);
        in_valid = 1'b1;
        t = 0;
        while (!in_ready && t < 50) begin
            @(negedge clk);
            t++;
        end
        if (t >= 50) begin
            n_cmp++;
            n_err++;
            $display("FAIL send_timeout: in_ready stuck at %0d, expected 1", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic send_group(input logic [127:0] w);
        for (int b = 0; b < 4; b++) begin
            send_beat(w);
        end
    endtask

    task automatic drain(input string name);
        int t;
        t = 0;
        while (exp_q.size() != 0 && t < 100) begin
            @(negedge clk);
            t++;
        end
        check({name, "_pending"}, exp_q.size(), 0);
        check({name, "_out_valid"}, longint'(out_valid), 0);
    endtask

    // Observes pops one time unit before the edge that performs them.
    always begin
        @(negedge clk);
        #4;
        if (mon_en && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_sample: got %0d, expected no sample", out_sample);
            end else begin
                check("sample", longint'(out_sample), exp_q.pop_front());
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, expected completion");
        $fatal(1);
    end

    initial begin
        int acc_cnt;

        vecs[0] = mkv(mk(8'h00, 8'h00, 8'h00, 8'h00), mk(8'h00, 8'h00, 8'h00, 8'h00),
                      mk(8'h00, 8'h00, 8'h00, 8'h00), mk(8'h00, 8'h00, 8'h00, 8'h00), -4080);
        vecs[1] = mkv(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), mk(8'hFF, 8'hFF, 8'hFF, 8'hFF),
                      mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), mk(8'hFF, 8'hFF, 8'hFF, 8'hFF), 4080);
        vecs[2] = mkv(mk(8'h80, 8'h80, 8'h80, 8'h80), mk(8'h80, 8'h80, 8'h80, 8'h80),
                      mk(8'h80, 8'h80, 8'h80, 8'h80), mk(8'h80, 8'h80, 8'h80, 8'h80), 16);
        vecs[3] = mkv(mk(8'hFF, 8'h00, 8'h00, 8'h00), mk(8'h00, 8'hFF, 8'h00, 8'h00),
                      mk(8'h00, 8'h00, 8'hFF, 8'h00), mk(8'h00, 8'h00, 8'h00, 8'hFF), -2040);
        vecs[4] = mkv(mk(8'h7F, 8'h80, 8'h7F, 8'h80), mk(8'h7F, 8'h80, 8'h7F, 8'h80),
                      mk(8'h7F, 8'h80, 8'h7F, 8'h80), mk(8'h7F, 8'h80, 8'h7F, 8'h80), 0);
        vecs[5] = mkv(mk(8'h10, 8'h20, 8'h30, 8'h40), mk(8'h00, 8'h00, 8'h00, 8'h00),
                      mk(8'hF0, 8'hF0, 8'hF0, 8'hF0), mk(8'h01, 8'h01, 8'h01, 8'h01), -1832);
        vecs[6] = mkv(mk(8'h01, 8'h02, 8'h03, 8'h04), mk(8'h01, 8'h02, 8'h03, 8'h04),
                      mk(8'h01, 8'h02, 8'h03, 8'h04), mk(8'h01, 8'h02, 8'h03, 8'h04), -4000);

        // Reset held with in_valid high
        reset     = 1'b0;
        in_valid  = 1'b1;
        flush     = 1'b0;
        out_ready = 1'b0;
        drive(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        repeat (3) begin
            @(negedge clk);
            check("rst_out_valid", longint'(out_valid), 0);
            check("rst_in_ready", longint'(in_ready), 0);
            check("rst_phase", longint'(acc_phase), 0);
        end
        check("rst_out_sample", longint'(out_sample), 0);
        reset    = 1'b1;
        in_valid = 1'b0;
        @(negedge clk);
        check("ready_after_rst", longint'(in_ready), 1);

        // Latency: sample visible two edges after the 4th accept
        out_ready = 1'b1;
        send_group(mk(8'h00, 8'h00, 8'h00, 8'h00));
        check("lat_not_yet", longint'(out_valid), 0);
        @(negedge clk);
        check("lat_valid", longint'(out_valid), 1);
        check("lat_sample", longint'(out_sample), -4080);
        @(negedge clk);
        check("lat_single", longint'(out_valid), 0);

        // Table of directed vectors, streamed with out_ready high
        mon_en = 1'b1;
        for (int i = 0; i < 7; i++) begin
            exp_q.push_back(longint'(vecs[i].exp));
            for (int b = 0; b < 4; b++) begin
                send_beat(vecs[i].beats[b]);
            end
        end
        drain("table");

        // Back-pressure: two samples fill the credit, 8 beats only
        mon_en    = 1'b0;
        out_ready = 1'b0;
        acc_cnt   = 0;
        in_valid  = 1'b1;
        for (int c = 0; c < 20; c++) begin
            drive((acc_cnt < 4) ? mk(8'h00, 8'h00, 8'h00, 8'h00)
                                : mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
            if (in_ready) acc_cnt++;
            if (out_valid) check("bp_stable", longint'(out_sample), -4080);
            @(negedge clk);
        end
        check("bp_accepted", acc_cnt, 8);
        check("bp_in_ready", longint'(in_ready), 0);
        check("bp_out_valid", longint'(out_valid), 1);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_head0", longint'(out_sample), -4080);
        @(negedge clk);
        check("bp_head1_valid", longint'(out_valid), 1);
        check("bp_head1", longint'(out_sample), 4080);
        @(negedge clk);
        check("bp_empty", longint'(out_valid), 0);
        check("bp_resume", longint'(in_ready), 1);

        // Flush after 2 beats, with a beat offered on the flush edge
        mon_en = 1'b1;
        send_beat(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        send_beat(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        check("phase_two", longint'(acc_phase), 2);
        drive(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        in_valid = 1'b1;
        flush    = 1'b1;
        @(negedge clk);
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_phase", longint'(acc_phase), 0);
        exp_q.push_back(-4080);
        send_group(mk(8'h00, 8'h00, 8'h00, 8'h00));
        drain("flush_partial");

        // Flush while the final beat sits in stage 1: that sample is dropped
        send_group(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        check("flush_last_phase", longint'(acc_phase), 0);
        exp_q.push_back(-4080);
        send_group(mk(8'h00, 8'h00, 8'h00, 8'h00));
        drain("flush_last");

        // Reset mid-accumulation with one sample buffered
        mon_en    = 1'b0;
        out_ready = 1'b0;
        send_group(mk(8'h00, 8'h00, 8'h00, 8'h00));
        @(negedge clk);
        check("mid_buffered", longint'(out_valid), 1);
        send_beat(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        send_beat(mk(8'hFF, 8'hFF, 8'hFF, 8'hFF));
        reset = 1'b0;
        @(negedge clk);
        check("mid_rst_valid", longint'(out_valid), 0);
        check("mid_rst_phase", longint'(acc_phase), 0);
        check("mid_rst_ready", longint'(in_ready), 0);
        reset     = 1'b1;
        out_ready = 1'b1;
        mon_en    = 1'b1;
        exp_q.push_back(longint'(vecs[6].exp));
        for (int b = 0; b < 4; b++) begin
            send_beat(vecs[6].beats[b]);
        end
        drain("post_reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
